// File: rtl/multi_ch_timestamp_if.sv
// Channel sample bus into multi_ch_timestamp and first-word-fall-through event FIFO head out.
interface multi_ch_timestamp_if #(
    parameter int NCH    = 4,
    parameter int CNTR_W = 10
);
    logic [NCH*CNTR_W-1:0] cntr;
    logic [NCH-1:0]        cntr_valid;
    logic [31:0]           data_out;
    logic                  data_out_valid;
    logic                  data_out_read;

    modport master (output cntr, cntr_valid, data_out_read, input data_out, data_out_valid);
    modport slave  (input cntr, cntr_valid, data_out_read, output data_out, data_out_valid);
endinterface

// File: rtl/multi_ch_timestamp.sv
// Per-channel threshold-crossing detector that timestamps events into a shared FWFT FIFO.
// Optional MCTS_DROP_CNT_EN adds a saturating drop_cnt output counting lost events.
module multi_ch_timestamp #(
    parameter int          NCH        = 4,
    parameter int          CNTR_W     = 10,
    parameter int unsigned THRESH     = 512,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    multi_ch_timestamp_if.slave bus
`ifdef MCTS_DROP_CNT_EN
    ,
    output logic [15:0]         drop_cnt
`endif
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    typedef enum logic {ARMED = 1'b0, WAIT_LOW = 1'b1} ch_state_e;

    logic [27:0]    timer;
    ch_state_e      state_q [NCH];
    ch_state_e      state_d [NCH];
    logic [NCH-1:0] above;
    logic [NCH-1:0] evt;
    logic [NCH-1:0] pend_v;
    logic [NCH-1:0] grant_oh;
    logic [27:0]    pend_ts [NCH];
    logic [3:0]     grant_id;
    logic [27:0]    grant_ts;
    logic           push;
    logic           pop;
    logic           empty;
    logic           full;
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic [31:0]    mem [FIFO_DEPTH];

    // NOTE: sequential state uses <= so every register sees only pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) timer <= '0;
        else      timer <= timer + 28'd1;
    end

    always_comb begin
        for (int i = 0; i < NCH; i++)
            above[i] = 32'(bus.cntr[i*CNTR_W +: CNTR_W]) >= THRESH;
    end

    // NOTE: defaults come first in every always_comb so no path can infer a latch.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            evt[i]     = 1'b0;
            if (bus.cntr_valid[i]) begin
                case (state_q[i])
                    ARMED: begin
                        if (above[i]) begin
                            state_d[i] = WAIT_LOW;
                            evt[i]     = 1'b1;
                        end
                    end
                    WAIT_LOW: if (!above[i]) state_d[i] = ARMED;
                    default:  state_d[i] = ARMED;
                endcase
            end
        end
    end

    // Fixed priority: the lowest-index occupied pending register wins the write slot.
    assign grant_oh = pend_v & (~pend_v + NCH'(1));

    always_comb begin
        grant_id = '0;
        grant_ts = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (pend_v[i]) begin
                grant_id = 4'(i);
                grant_ts = pend_ts[i];
            end
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = bus.data_out_read && !empty;
    assign push  = (|pend_v) && (!full || pop);

    // A register being drained this edge still counts as occupied, so a same-edge event is lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_v <= '0;
            for (int i = 0; i < NCH; i++) state_q[i] <= ARMED;
        end else begin
            state_q <= state_d;
            for (int i = 0; i < NCH; i++) begin
                if (push && grant_oh[i])        pend_v[i] <= 1'b0;
                else if (evt[i] && !pend_v[i])  pend_v[i] <= 1'b1;
            end
        end
    end

    // NOTE: payload storage has no reset; pend_v and the FIFO pointers define what is live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++)
            if (evt[i] && !pend_v[i]) pend_ts[i] <= timer;
        if (push) mem[wr_ptr[AW-1:0]] <= {grant_id, grant_ts};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    assign bus.data_out_valid = !empty;
    assign bus.data_out       = empty ? 32'h0 : mem[rd_ptr[AW-1:0]];

`ifdef MCTS_DROP_CNT_EN
    logic [NCH-1:0] drop;
    logic [4:0]     drop_n;
    logic [16:0]    drop_sum;

    assign drop = evt & pend_v;

    always_comb begin
        drop_n = '0;
        for (int i = 0; i < NCH; i++) drop_n = drop_n + 5'(drop[i]);
    end

    assign drop_sum = {1'b0, drop_cnt} + {12'd0, drop_n};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) drop_cnt <= '0;
        else      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
`endif
endmodule

// File: tb/tb_multi_ch_timestamp.sv
// Self-checking bench for multi_ch_timestamp: directed scenarios plus randomized traffic vs a queue model.
module tb_multi_ch_timestamp;
    localparam int NCH    = 4;
    localparam int CNTR_W = 10;
    localparam int THRESH = 512;
    localparam int DEPTH  = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    multi_ch_timestamp_if #(.NCH(NCH), .CNTR_W(CNTR_W)) bus ();
`ifdef MCTS_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    multi_ch_timestamp #(
        .NCH(NCH), .CNTR_W(CNTR_W), .THRESH(THRESH), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef MCTS_DROP_CNT_EN
        ,
        .drop_cnt(drop_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: channel arming flags, one-slot pending per channel, a queue for the FIFO.
    int          m_timer;
    bit          m_armed [NCH];
    bit          m_pv    [NCH];
    int          m_pts   [NCH];
    logic [31:0] m_q[$];
    int          m_drops;

    task automatic model_step();
        int                g;
        bit                pv_old [NCH];
        logic [CNTR_W-1:0] s;
        g = -1;
        for (int i = NCH - 1; i >= 0; i--) if (m_pv[i]) g = i;
        if (bus.data_out_read && m_q.size() > 0) void'(m_q.pop_front());
        pv_old = m_pv;
        if (g >= 0 && m_q.size() < DEPTH) begin
            m_q.push_back({4'(g), 28'(m_pts[g])});
            m_pv[g] = 1'b0;
        end
        for (int i = 0; i < NCH; i++) begin
            s = bus.cntr[i*CNTR_W +: CNTR_W];
            if (bus.cntr_valid[i]) begin
                if (m_armed[i] && s >= THRESH) begin
                    if (pv_old[i]) begin
                        if (m_drops < 65535) m_drops++;
                    end else begin
                        m_pv[i]  = 1'b1;
                        m_pts[i] = m_timer;
                    end
                end
                m_armed[i] = (s < THRESH);
            end
        end
        m_timer = (m_timer + 1) & 32'h0FFF_FFFF;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_timer = 0;
            m_drops = 0;
            m_q.delete();
            for (int i = 0; i < NCH; i++) begin
                m_armed[i] = 1'b1;
                m_pv[i]    = 1'b0;
                m_pts[i]   = 0;
            end
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("valid", 32'(bus.data_out_valid), 32'(m_q.size() > 0));
            check("data", bus.data_out, (m_q.size() > 0) ? m_q[0] : 32'h0);
`ifdef MCTS_DROP_CNT_EN
            check("drop_cnt", 32'(drop_cnt), 32'(m_drops));
`endif
        end
    end

    task automatic set_in(input logic [NCH-1:0] v, input int samp, input bit rd);
        for (int i = 0; i < NCH; i++) bus.cntr[i*CNTR_W +: CNTR_W] = CNTR_W'(samp);
        bus.cntr_valid    = v;
        bus.data_out_read = rd;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wait_timer(input int t);
        set_in('0, 0, 1'b0);
        for (int k = 0; k < 1000 && m_timer != t; k++) @(negedge clk);
        check("timer_wait", 32'(m_timer), 32'(t));
    endtask

    task automatic rand_cycles(input int n, input int rd_pct);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < NCH; i++)
                bus.cntr[i*CNTR_W +: CNTR_W] = ($urandom_range(0, 3) == 0) ?
                    CNTR_W'($urandom_range(0, 1023)) : CNTR_W'(THRESH - 2 + $urandom_range(0, 3));
            bus.cntr_valid    = NCH'($urandom);
            bus.data_out_read = ($urandom_range(0, 99) < rd_pct);
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        set_in('0, 0, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(bus.data_out_valid), 32'h0);
        check("rst_data", bus.data_out, 32'h0);
        #2 rst = 1'b1;

        // Re-arm between events on one channel: two entries in order.
        wait_timer(32'h10);
        set_in(4'b0001, 600, 1'b0); cyc();
        set_in(4'b0001, 100, 1'b0); cyc();
        set_in(4'b0001, 600, 1'b0); cyc();
        set_in('0, 0, 1'b0);        cyc();
        check("rearm_first", bus.data_out, 32'h0000_0010);
        set_in('0, 0, 1'b1); cyc();
        check("rearm_second", bus.data_out, 32'h0000_0012);
        set_in('0, 0, 1'b1); cyc();
        check("rearm_empty", 32'(bus.data_out_valid), 32'h0);

        // Simultaneous events on ch2 and ch1: lower index first.
        wait_timer(32'h20);
        set_in(4'b0110, 600, 1'b0); cyc();
        set_in('0, 0, 1'b0);        cyc(); cyc();
        check("prio_ch1", bus.data_out, 32'h1000_0020);
        set_in('0, 0, 1'b1); cyc();
        check("prio_ch2", bus.data_out, 32'h2000_0020);
        set_in('0, 0, 1'b1); cyc();
        check("prio_empty", 32'(bus.data_out_valid), 32'h0);
        set_in(4'b0110, 100, 1'b0); cyc();

        // Single event at timer 0x40, second high sample ignored.
        wait_timer(32'h3F);
        set_in(4'b0001, 100, 1'b0); cyc();
        set_in(4'b0001, 600, 1'b0); cyc();
        set_in(4'b0001, 700, 1'b0); cyc();
        set_in('0, 0, 1'b0);        cyc();
        check("evt40_valid", 32'(bus.data_out_valid), 32'h1);
        check("evt40_data", bus.data_out, 32'h0000_0040);
        set_in('0, 0, 1'b1); cyc();
        set_in('0, 0, 1'b0); cyc(); cyc();
        check("evt40_noretrig", 32'(bus.data_out_valid), 32'h0);
        set_in(4'b0001, 100, 1'b0); cyc();

        // Fill FIFO with 17 events, then ch3 fires twice while its pending slot is held.
        for (int k = 0; k < 17; k++) begin
            set_in(NCH'(1 << (k % NCH)), 600, 1'b0); cyc();
            set_in(NCH'(1 << (k % NCH)), 100, 1'b0); cyc();
        end
        for (int k = 0; k < 2; k++) begin
            set_in(4'b1000, 600, 1'b0); cyc();
            set_in(4'b1000, 100, 1'b0); cyc();
        end
        set_in('0, 0, 1'b0); cyc();
        check("full_valid", 32'(bus.data_out_valid), 32'h1);
`ifdef MCTS_DROP_CNT_EN
        check("drop_one", 32'(drop_cnt), 32'h1);
`endif
        n = 0;
        for (int k = 0; k < 100 && bus.data_out_valid; k++) begin
            set_in('0, 0, 1'b1); cyc();
            n++;
        end
        set_in('0, 0, 1'b0);
        check("drain_count", 32'(n), 32'd18);

        rand_cycles(1500, 25);

        // Queue something, then assert reset mid-stream.
        set_in('1, 100, 1'b0); cyc();
        set_in('1, 600, 1'b0); cyc();
        set_in('0, 0, 1'b0);   cyc(); cyc();
        check("pre_rst_valid", 32'(bus.data_out_valid), 32'h1);
        #2 rst = 1'b0;
        #1;
        check("midrst_valid", 32'(bus.data_out_valid), 32'h0);
        check("midrst_data", bus.data_out, 32'h0);
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);

        rand_cycles(1500, 75);
        set_in('0, 0, 1'b1);
        repeat (DEPTH + NCH + 2) @(negedge clk);
        check("final_empty", 32'(bus.data_out_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
